// File: rtl/mel_pkg.sv
// Shared defaults and FSM state encoding for the mel frame sequencer.
package mel_pkg;

   localparam int unsigned NUM_FILTERS_DEFAULT  = 26;
   localparam int unsigned N_FFT_DEFAULT        = 512;
   localparam int unsigned DATA_WIDTH_DEFAULT   = 32;
   localparam int unsigned READ_LATENCY_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STREAM  = 2'd1,
      WAIT_FB = 2'd2,
      DRAIN   = 2'd3
   } mel_state_e;

endpackage

// File: rtl/mel_frame_sequencer_if.sv
// Frame-start, power-buffer, filterbank and mel-output signals of the sequencer.
interface mel_frame_sequencer_if
   import mel_pkg::*;
#(
   parameter int unsigned NUM_FILTERS = NUM_FILTERS_DEFAULT,
   parameter int unsigned N_FFT       = N_FFT_DEFAULT,
   parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT
) ();

   localparam int unsigned ADDR_W = $clog2(N_FFT) + 1;
   localparam int unsigned IDX_W  = $clog2(NUM_FILTERS);

   logic                                   frame_start_in;
   logic                                   frame_bank_in;
   logic [ADDR_W-1:0]                      pbuf_addr_out;
   logic [DATA_WIDTH-1:0]                  pbuf_data_in;
   logic [DATA_WIDTH-1:0]                  fb_data_out;
   logic                                   fb_valid_out;
   logic                                   fb_last_out;
   logic                                   fb_ready_in;
   logic [NUM_FILTERS-1:0][DATA_WIDTH-1:0] fb_filtered_data_in;
   logic                                   fb_filtered_valid_in;
   logic                                   fb_filtered_ready_out;
   logic [DATA_WIDTH-1:0]                  mel_data_out;
   logic [IDX_W-1:0]                       mel_index_out;
   logic                                   mel_valid_out;
   logic                                   mel_last_out;
   logic                                   mel_ready_in;
   logic                                   busy_out;
   logic                                   overrun_out;

   // Sequencer side
   modport master (
      input  frame_start_in, frame_bank_in, pbuf_data_in, fb_ready_in,
             fb_filtered_data_in, fb_filtered_valid_in, mel_ready_in,
      output pbuf_addr_out, fb_data_out, fb_valid_out, fb_last_out,
             fb_filtered_ready_out, mel_data_out, mel_index_out,
             mel_valid_out, mel_last_out, busy_out, overrun_out
   );

   // Environment side (frame producer, BRAM, filterbank, mel consumer)
   modport slave (
      output frame_start_in, frame_bank_in, pbuf_data_in, fb_ready_in,
             fb_filtered_data_in, fb_filtered_valid_in, mel_ready_in,
      input  pbuf_addr_out, fb_data_out, fb_valid_out, fb_last_out,
             fb_filtered_ready_out, mel_data_out, mel_index_out,
             mel_valid_out, mel_last_out, busy_out, overrun_out
   );

endinterface

// File: rtl/pbuf_skid_fifo.sv
// Show-ahead skid FIFO absorbing power-buffer read returns while the filterbank stalls.
module pbuf_skid_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr];

   // Storage, pointers and occupancy; storage cleared so the head reads zero after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr] <= wdata;
            wr_ptr        <= bump(wr_ptr);
         end
         if (do_pop) rd_ptr <= bump(rd_ptr);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (do_pop && !do_push) count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/mel_frame_sequencer.sv
// Streams a power frame from the ping-pong buffer to the filterbank, then serializes the mel energies.
module mel_frame_sequencer
   import mel_pkg::*;
#(
   parameter int unsigned NUM_FILTERS  = NUM_FILTERS_DEFAULT,
   parameter int unsigned N_FFT        = N_FFT_DEFAULT,
   parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEFAULT,
   parameter int unsigned READ_LATENCY = READ_LATENCY_DEFAULT
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   mel_frame_sequencer_if.master bus
);

   localparam int unsigned BIN_W = $clog2(N_FFT);
   localparam int unsigned RD_W  = BIN_W + 1;
   localparam int unsigned IDX_W = $clog2(NUM_FILTERS);
   localparam int unsigned DEPTH = READ_LATENCY + 2;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W = $clog2(2 * DEPTH + 1) + 1;

   mel_state_e                             state;
   logic                                   bank_q;
   logic [RD_W-1:0]                        rd_bin;
   logic [BIN_W-1:0]                       tx_bin;
   logic [READ_LATENCY:0]                  rd_pipe;
   logic [RD_W-1:0]                        addr_q;
   logic [NUM_FILTERS-1:0][DATA_WIDTH-1:0] cap_q;
   logic [IDX_W-1:0]                       mel_idx;
   logic [DATA_WIDTH-1:0]                  mel_data_q;
   logic                                   mel_valid_q;
   logic                                   mel_last_q;
   logic                                   busy_q;
   logic                                   overrun_q;

   logic                  fifo_push_c;
   logic                  fifo_pop_c;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic [CNT_W-1:0]      fifo_count;
   logic                  fb_valid_c;
   logic                  fb_last_c;
   logic                  issue_c;
   logic [SUM_W-1:0]      inflight_c;
   logic [SUM_W-1:0]      budget_c;
   logic [IDX_W-1:0]      mel_nxt_c;

   // rd_pipe[READ_LATENCY] marks the cycle a read's data sits on pbuf_data_in
   assign fifo_push_c = rd_pipe[READ_LATENCY] && !fifo_full;
   assign fb_valid_c  = !fifo_empty;
   assign fifo_pop_c  = fb_valid_c && bus.fb_ready_in;
   assign fb_last_c   = fb_valid_c && (tx_bin == BIN_W'(N_FFT - 1));
   assign mel_nxt_c   = mel_idx + IDX_W'(1);

   // Read issue: occupancy is counted after this cycle's pop so a free-running stream has no bubbles
   always_comb begin
      inflight_c = '0;
      for (int unsigned i = 0; i <= READ_LATENCY; i++) inflight_c = inflight_c + SUM_W'(rd_pipe[i]);
      budget_c = SUM_W'(fifo_count) - SUM_W'(fifo_pop_c) + inflight_c;
      issue_c  = (state == STREAM) && (rd_bin < RD_W'(N_FFT)) && (budget_c < SUM_W'(DEPTH));
   end

   pbuf_skid_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk   (clk_in),
      .rst   (rst_in),
      .push  (fifo_push_c),
      .pop   (fifo_pop_c),
      .wdata (bus.pbuf_data_in),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.pbuf_addr_out         = addr_q;
   assign bus.fb_data_out           = fifo_head;
   assign bus.fb_valid_out          = fb_valid_c;
   assign bus.fb_last_out           = fb_last_c;
   assign bus.fb_filtered_ready_out = (state == WAIT_FB);
   assign bus.mel_data_out          = mel_data_q;
   assign bus.mel_index_out         = mel_idx;
   assign bus.mel_valid_out         = mel_valid_q;
   assign bus.mel_last_out          = mel_last_q;
   assign bus.busy_out              = busy_q;
   assign bus.overrun_out           = overrun_q;

   // Frame FSM with read issue, capture and mel serialization
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state       <= IDLE;
         bank_q      <= 1'b0;
         rd_bin      <= '0;
         tx_bin      <= '0;
         rd_pipe     <= '0;
         addr_q      <= '0;
         cap_q       <= '0;
         mel_idx     <= '0;
         mel_data_q  <= '0;
         mel_valid_q <= 1'b0;
         mel_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         overrun_q <= bus.frame_start_in && (state != IDLE);
         rd_pipe   <= {rd_pipe[READ_LATENCY-1:0], issue_c};
         if (issue_c) begin
            addr_q <= {bank_q, rd_bin[BIN_W-1:0]};
            rd_bin <= rd_bin + RD_W'(1);
         end
         if (fifo_pop_c) tx_bin <= tx_bin + BIN_W'(1);
         case (state)
            IDLE: begin
               if (bus.frame_start_in) begin
                  bank_q <= bus.frame_bank_in;
                  rd_bin <= '0;
                  tx_bin <= '0;
                  busy_q <= 1'b1;
                  state  <= STREAM;
               end
            end
            STREAM: begin
               if (fifo_pop_c && fb_last_c) state <= WAIT_FB;
            end
            WAIT_FB: begin
               if (bus.fb_filtered_valid_in) begin
                  cap_q       <= bus.fb_filtered_data_in;
                  mel_data_q  <= bus.fb_filtered_data_in[0];
                  mel_idx     <= '0;
                  mel_valid_q <= 1'b1;
                  mel_last_q  <= (NUM_FILTERS == 1);
                  state       <= DRAIN;
               end
            end
            DRAIN: begin
               if (bus.mel_ready_in) begin
                  if (mel_last_q) begin
                     mel_valid_q <= 1'b0;
                     mel_last_q  <= 1'b0;
                     busy_q      <= 1'b0;
                     state       <= IDLE;
                  end else begin
                     mel_idx    <= mel_nxt_c;
                     mel_data_q <= cap_q[mel_nxt_c];
                     mel_last_q <= (mel_nxt_c == IDX_W'(NUM_FILTERS - 1));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mel_frame_sequencer.sv
// Frame-level bench: table of frame scenarios, random handshakes, queue-free reference of expected bins/energies.
module tb_mel_frame_sequencer;
   import mel_pkg::*;

   localparam int unsigned NF = NUM_FILTERS_DEFAULT;
   localparam int unsigned NB = N_FFT_DEFAULT;
   localparam int unsigned DW = DATA_WIDTH_DEFAULT;
   localparam int unsigned RL = READ_LATENCY_DEFAULT;
   localparam int unsigned AW = $clog2(NB) + 1;

   typedef struct {
      int bank;
      int data_mode;   // 0: constant 0xBEEF, 1: bin index, 2: full address
      int fb_pct;
      int mel_pct;
      int filt_rand;   // 0: word k = 0x1000+k, 1: random words
      int ovr_stream;
      int ovr_drain;
      int exp_lat;     // expected cycles from start edge to first fb_valid, -1 = unchecked
      int exp_ovr;     // expected overrun pulses for the frame
   } frame_vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mel_frame_sequencer_if #(.NUM_FILTERS(NF), .N_FFT(NB), .DATA_WIDTH(DW)) bus ();

   mel_frame_sequencer #(
      .NUM_FILTERS  (NF),
      .N_FFT        (NB),
      .DATA_WIDTH   (DW),
      .READ_LATENCY (RL)
   ) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int bram_mode = 0;
   int ovr_cnt  = 0;
   bit ovr_pending = 1'b0;

   // BRAM model: READ_LATENCY register stages behind the address
   logic [DW-1:0] rd_q [RL];
   function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a);
      if (bram_mode == 0) return DW'(32'hBEEF);
      if (bram_mode == 1) return DW'(a) & DW'(NB - 1);
      return DW'(a);
   endfunction
   always @(posedge clk) begin
      rd_q[0] <= bram_word(bus.pbuf_addr_out);
      for (int i = 1; i < RL; i++) rd_q[i] <= rd_q[i-1];
   end
   assign bus.pbuf_data_in = rd_q[RL-1];

   function automatic logic [DW-1:0] exp_bin(input int mode_i, input int bank, input int i);
      if (mode_i == 0) return DW'(32'hBEEF);
      if (mode_i == 1) return DW'(i);
      return DW'(bank * int'(NB) + i);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      bus.frame_start_in = 1'b0;
      check("overrun", 64'(bus.overrun_out), 64'(ovr_pending));
      if (bus.overrun_out === 1'b1) ovr_cnt++;
      ovr_pending = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      $display("reset check: %s", tag);
      check("rst_fb_valid",   64'(bus.fb_valid_out), 64'(0));
      check("rst_fb_last",    64'(bus.fb_last_out), 64'(0));
      check("rst_fb_data",    64'(bus.fb_data_out), 64'(0));
      check("rst_addr",       64'(bus.pbuf_addr_out), 64'(0));
      check("rst_filt_ready", 64'(bus.fb_filtered_ready_out), 64'(0));
      check("rst_mel_valid",  64'(bus.mel_valid_out), 64'(0));
      check("rst_mel_last",   64'(bus.mel_last_out), 64'(0));
      check("rst_mel_data",   64'(bus.mel_data_out), 64'(0));
      check("rst_mel_index",  64'(bus.mel_index_out), 64'(0));
      check("rst_busy",       64'(bus.busy_out), 64'(0));
      check("rst_overrun",    64'(bus.overrun_out), 64'(0));
   endtask

   task automatic run_frame(input frame_vec_t v, input int abort_at);
      logic [DW-1:0] words [NF];
      logic [DW-1:0] prev_data;
      bit prev_stall;
      bit rdy;
      int got, cyc, first_lat, bubbles, idx, dc, w;
      bram_mode  = v.data_mode;
      ovr_cnt    = 0;
      got        = 0;
      cyc        = 0;
      first_lat  = -1;
      bubbles    = 0;
      prev_stall = 1'b0;
      prev_data  = '0;
      bus.frame_start_in = 1'b1;
      bus.frame_bank_in  = 1'(v.bank);
      ovr_pending = 1'b0;
      step();
      check("busy_start", 64'(bus.busy_out), 64'(1));
      check("filt_ready_stream", 64'(bus.fb_filtered_ready_out), 64'(0));
      while (got < int'(NB) && cyc < 20000) begin
         if (abort_at >= 0 && got == abort_at) begin
            rst = 1'b1;
            #1;
            check_reset_outputs("mid-frame");
            @(posedge clk);
            #1;
            rst = 1'b0;
            bus.fb_ready_in = 1'b0;
            ovr_pending = 1'b0;
            repeat (3) step();
            return;
         end
         rdy = ($urandom_range(99) < 32'(v.fb_pct));
         bus.fb_ready_in = rdy;
         if (v.ovr_stream != 0 && cyc == 50) begin
            bus.frame_start_in = 1'b1;
            bus.frame_bank_in  = ~1'(v.bank);
            ovr_pending = 1'b1;
         end
         if (prev_stall) begin
            check("fb_hold_valid", 64'(bus.fb_valid_out), 64'(1));
            check("fb_hold_data", 64'(bus.fb_data_out), 64'(prev_data));
         end
         if (bus.fb_valid_out === 1'b1) begin
            if (first_lat < 0) first_lat = cyc;
            check("fb_data", 64'(bus.fb_data_out), 64'(exp_bin(v.data_mode, v.bank, got)));
            check("fb_last", 64'(bus.fb_last_out), 64'(got == int'(NB) - 1));
            if (rdy) got++;
         end else if (first_lat >= 0) begin
            bubbles++;
         end
         prev_stall = (bus.fb_valid_out === 1'b1) && !rdy;
         prev_data  = bus.fb_data_out;
         step();
         cyc++;
      end
      bus.fb_ready_in = 1'b0;
      check("stream_complete", 64'(got), 64'(NB));
      if (v.exp_lat >= 0) check("first_valid_latency", 64'(first_lat), 64'(v.exp_lat));
      if (v.fb_pct == 100) check("fb_bubbles", 64'(bubbles), 64'(0));
      check("filt_ready_wait", 64'(bus.fb_filtered_ready_out), 64'(1));
      check("fb_valid_after_frame", 64'(bus.fb_valid_out), 64'(0));
      w = int'($urandom_range(3));
      repeat (w) step();
      check("filt_ready_hold", 64'(bus.fb_filtered_ready_out), 64'(1));
      for (int k = 0; k < int'(NF); k++) begin
         words[k] = (v.filt_rand != 0) ? DW'($urandom) : DW'(32'h1000 + k);
         bus.fb_filtered_data_in[k] = words[k];
      end
      bus.fb_filtered_valid_in = 1'b1;
      step();
      bus.fb_filtered_valid_in = 1'b0;
      check("filt_ready_drain", 64'(bus.fb_filtered_ready_out), 64'(0));
      idx = 0;
      dc  = 0;
      while (idx < int'(NF) && dc < 5000) begin
         rdy = ($urandom_range(99) < 32'(v.mel_pct));
         bus.mel_ready_in = rdy;
         check("mel_valid", 64'(bus.mel_valid_out), 64'(1));
         check("mel_index", 64'(bus.mel_index_out), 64'(idx));
         check("mel_data",  64'(bus.mel_data_out), 64'(words[idx]));
         check("mel_last",  64'(bus.mel_last_out), 64'(idx == int'(NF) - 1));
         if (rdy) begin
            if (idx == int'(NF) - 1 && v.ovr_drain != 0) begin
               bus.frame_start_in = 1'b1;
               ovr_pending = 1'b1;
            end
            idx++;
         end
         step();
         dc++;
      end
      bus.mel_ready_in = 1'b0;
      check("drain_complete", 64'(idx), 64'(NF));
      check("idle_busy", 64'(bus.busy_out), 64'(0));
      check("idle_mel_valid", 64'(bus.mel_valid_out), 64'(0));
      check("overrun_count", 64'(ovr_cnt), 64'(v.exp_ovr));
      repeat (2) step();
   endtask

   frame_vec_t vecs [6];
   frame_vec_t abort_vec;

   initial begin
      rst = 1'b1;
      bus.frame_start_in       = 1'b0;
      bus.frame_bank_in        = 1'b0;
      bus.fb_ready_in          = 1'b0;
      bus.fb_filtered_data_in  = '0;
      bus.fb_filtered_valid_in = 1'b0;
      bus.mel_ready_in         = 1'b0;
      //          bank mode fb%  mel% rand ovrS ovrD lat ovr
      vecs[0] = '{0,   0,   100, 100, 0,   0,   0,   4,  0};
      vecs[1] = '{1,   1,   50,  100, 0,   0,   0,   -1, 0};
      vecs[2] = '{0,   2,   100, 50,  1,   0,   0,   4,  0};
      vecs[3] = '{1,   1,   70,  60,  0,   1,   1,   -1, 2};
      vecs[4] = '{0,   2,   30,  30,  1,   0,   0,   -1, 0};
      vecs[5] = '{1,   2,   100, 70,  1,   0,   0,   4,  0};
      abort_vec = '{0, 2,   100, 100, 1,   0,   0,   4,  0};

      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("power-on");
      rst = 1'b0;
      repeat (2) step();

      for (int v = 0; v < 5; v++) run_frame(vecs[v], -1);
      run_frame(abort_vec, 200);
      run_frame(vecs[5], -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
